// File: rtl/mx_dot_seq.sv
// MX block dot-product sequencer: one shared combinational mul_fp, exact fixed-point accumulation.
// Optional E8M0 shared-scale outputs are enabled by defining MX_DOT_SCALE_EN.

module mul_fp #(
    parameter int exp_width = 5,
    parameter int man_width = 2,
    localparam int bit_width = 1 + exp_width + man_width,
    localparam int prd_width = 2 * ((1 << exp_width) + man_width)
) (
    input  logic [bit_width-1:0] i_op0,
    input  logic [bit_width-1:0] i_op1,
    output logic [prd_width-1:0] o_prd
);
    localparam int mag_width = prd_width / 2;

    // Magnitude in units of the minimum subnormal; exp 0 has no hidden bit but the same scale as exp 1.
    function automatic logic [mag_width-1:0] fixed_mag(input logic [bit_width-1:0] op);
        logic [exp_width-1:0] e;
        logic [mag_width-1:0] sig;
        e = op[man_width +: exp_width];
        sig = '0;
        sig[man_width-1:0] = op[man_width-1:0];
        if (e != '0) begin
            sig[man_width] = 1'b1;
            sig = sig << (e - 1'b1);
        end
        return sig;
    endfunction

    logic [mag_width-1:0] mag0;
    logic [mag_width-1:0] mag1;
    logic [prd_width-1:0] mag_prd;
    logic                 neg;

    assign mag0    = fixed_mag(i_op0);
    assign mag1    = fixed_mag(i_op1);
    assign mag_prd = {{mag_width{1'b0}}, mag0} * {{mag_width{1'b0}}, mag1};
    assign neg     = i_op0[bit_width-1] ^ i_op1[bit_width-1];
    assign o_prd   = neg ? (~mag_prd + 1'b1) : mag_prd;
endmodule

module mx_dot_seq #(
    parameter int exp_width  = 5,
    parameter int man_width  = 2,
    parameter int BLOCK_SIZE = 32,
    localparam int bit_width = 1 + exp_width + man_width,
    localparam int prd_width = 2 * ((1 << exp_width) + man_width),
    localparam int acc_width = prd_width + $clog2(BLOCK_SIZE) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [bit_width-1:0] i_op0,
    input  logic [bit_width-1:0] i_op1,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [acc_width-1:0] o_acc,
    output logic                 o_busy
`ifdef MX_DOT_SCALE_EN
    ,
    input  logic [7:0]           i_scale0,
    input  logic [7:0]           i_scale1,
    output logic [9:0]           o_exp,
    output logic                 o_nan
`endif
);
    localparam int cnt_width = $clog2(BLOCK_SIZE + 1);
    localparam int ext_width = acc_width - prd_width;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t               state;
    state_t               next_state;
    logic [cnt_width-1:0] count;
    logic [prd_width-1:0] prd;
    logic [prd_width-1:0] prd_reg;
    logic                 prd_valid;
    logic [acc_width-1:0] acc;
    logic                 accept;
    logic                 last_pair;
    logic                 handshake;

    assign accept    = i_valid && o_ready;
    assign last_pair = accept && (count == cnt_width'(BLOCK_SIZE - 1));
    assign handshake = o_valid && i_ready;
    assign o_acc     = acc;

    mul_fp #(
        .exp_width(exp_width),
        .man_width(man_width)
    ) u_mul (
        .i_op0(i_op0),
        .i_op1(i_op1),
        .o_prd(prd)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            o_ready <= 1'b0;
        end else begin
            state   <= next_state;
            o_ready <= (next_state == IDLE) || (next_state == ACCUM);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        o_valid    = 1'b0;
        o_busy     = 1'b1;
        unique case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (accept) next_state = ACCUM;
            end
            ACCUM: if (last_pair) next_state = DRAIN;
            DRAIN: next_state = DONE;
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Stage 1 holds the product of the accepted pair; stage 2 folds it into the sign-extended sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prd_reg   <= '0;
            prd_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
        end else begin
            prd_valid <= accept;
            if (accept) begin
                prd_reg <= prd;
                count   <= count + 1'b1;
            end
            if (handshake) begin
                acc   <= '0;
                count <= '0;
            end else if (prd_valid) begin
                acc <= acc + {{ext_width{prd_reg[prd_width-1]}}, prd_reg};
            end
        end
    end

`ifdef MX_DOT_SCALE_EN
    // Scales are captured with the first pair of a block and held until the next block starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_exp <= '0;
            o_nan <= 1'b0;
        end else if (accept && state == IDLE) begin
            o_exp <= {2'b00, i_scale0} + {2'b00, i_scale1} - 10'd254;
            o_nan <= (i_scale0 == 8'hFF) || (i_scale1 == 8'hFF);
        end
    end
`endif
endmodule

// File: tb/tb_mx_dot_seq.sv
// Scoreboard bench for mx_dot_seq: driver pushes expected block results, a monitor pops and compares.
// Element values are modelled arithmetically; scale checks are active when MX_DOT_SCALE_EN is defined.

module tb_mx_dot_seq;
    localparam int exp_width  = 5;
    localparam int man_width  = 2;
    localparam int BLOCK_SIZE = 32;
    localparam int bit_width  = 1 + exp_width + man_width;
    localparam int prd_width  = 2 * ((1 << exp_width) + man_width);
    localparam int acc_width  = prd_width + $clog2(BLOCK_SIZE) + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 i_valid = 1'b0;
    logic                 i_ready = 1'b1;
    logic [bit_width-1:0] i_op0 = '0;
    logic [bit_width-1:0] i_op1 = '0;
    logic                 o_ready;
    logic                 o_valid;
    logic                 o_busy;
    logic [acc_width-1:0] o_acc;
    logic [7:0]           sc0 = 8'd127;
    logic [7:0]           sc1 = 8'd127;
`ifdef MX_DOT_SCALE_EN
    logic [9:0]           o_exp;
    logic                 o_nan;
`endif

    mx_dot_seq #(
        .exp_width(exp_width),
        .man_width(man_width),
        .BLOCK_SIZE(BLOCK_SIZE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_op0(i_op0),
        .i_op1(i_op1),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_acc(o_acc),
        .o_busy(o_busy)
`ifdef MX_DOT_SCALE_EN
        ,
        .i_scale0(sc0),
        .i_scale1(sc1),
        .o_exp(o_exp),
        .o_nan(o_nan)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    typedef struct {
        logic [acc_width-1:0] acc;
        int                   due;
        logic [9:0]           exp;
        logic                 nan;
    } result_t;

    result_t sb[$];

    logic [7:0] a_buf[BLOCK_SIZE];
    logic [7:0] b_buf[BLOCK_SIZE];
    int         hold_req = 0;

    // Real value of an element divided by the smallest subnormal (2^-16 for E5M2).
    function automatic logic signed [127:0] elem_val(input logic [7:0] c);
        int e;
        int m;
        logic signed [127:0] v;
        e = int'(c[6:2]);
        m = int'(c[1:0]);
        if (e == 0) v = 128'(m);
        else        v = 128'(4 + m) << (e - 1);
        return c[7] ? -v : v;
    endfunction

    function automatic void fill(input int lo, input int hi, input logic [7:0] a, input logic [7:0] b);
        for (int k = lo; k < hi; k++) begin
            a_buf[k] = a;
            b_buf[k] = b;
        end
    endfunction

    // Drives n pairs from the buffers with random gaps; starts and ends #1 after a rising edge.
    task automatic send(input int n, input int gap_pct, input bit push);
        logic signed [127:0] sum;
        int k;
        int waited;
        int last;
        result_t r;
        sum = 0;
        k = 0;
        waited = 0;
        last = 0;
        while (k < n) begin
            i_valid = ($urandom_range(99) >= gap_pct);
            i_op0 = i_valid ? a_buf[k] : 8'($urandom);
            i_op1 = i_valid ? b_buf[k] : 8'($urandom);
            @(negedge clk);
            if (o_ready) check("busy", o_busy, k > 0);
            if (i_valid && o_ready) begin
                sum += elem_val(a_buf[k]) * elem_val(b_buf[k]);
                k++;
                last = cyc;
                waited = 0;
            end else if (++waited > 200) begin
                fail("timeout waiting for o_ready");
                i_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (push) begin
            r.acc = sum[acc_width-1:0];
            r.due = last + 2;
            r.exp = 10'(int'(sc0) + int'(sc1) - 254);
            r.nan = (sc0 == 8'hFF) || (sc1 == 8'hFF);
            sb.push_back(r);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || o_valid) && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (t >= 200) fail("timeout waiting for result");
        @(posedge clk);
        #1;
    endtask

    // Consumer and monitor share one process so i_ready and the checks see a consistent cycle.
    initial begin
        bit in_res;
        bit post_hs;
        int hold_left;
        result_t r;
        logic [acc_width-1:0] held;
        in_res = 0;
        post_hs = 0;
        hold_left = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (post_hs) begin
                check("post_handshake_ready", o_ready, 1'b1);
                check("post_handshake_acc", o_acc, 0);
                check("post_handshake_valid", o_valid, 1'b0);
                post_hs = 0;
            end
            if (o_valid && rst_n) begin
                if (!in_res) begin
                    in_res = 1;
                    held = o_acc;
                    hold_left = hold_req;
                    if (sb.size() == 0) begin
                        fail("unexpected o_valid");
                    end else begin
                        r = sb.pop_front();
                        check("latency", 128'(cyc), 128'(r.due));
                        check("acc", o_acc, r.acc);
`ifdef MX_DOT_SCALE_EN
                        check("scale_exp", o_exp, r.exp);
                        check("scale_nan", o_nan, r.nan);
`endif
                    end
                end else begin
                    check("hold_acc", o_acc, held);
                    check("hold_ready", o_ready, 1'b0);
                end
                i_ready = (hold_left == 0);
                if (hold_left > 0) hold_left--;
                if (i_ready) begin
                    in_res = 0;
                    post_hs = 1;
                end
            end else begin
                i_ready = 1'b1;
            end
        end
    end

    initial begin
        #1;
        check("reset_ready", o_ready, 1'b0);
        check("reset_valid", o_valid, 1'b0);
        check("reset_acc", o_acc, 0);
        check("reset_busy", o_busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", o_ready, 1'b1);
        @(posedge clk);
        #1;

        sc0 = 8'd127; sc1 = 8'd130;
        fill(0, 32, 8'h01, 8'h01); send(32, 0, 1); drain();
        sc0 = 8'd255; sc1 = 8'd3;
        fill(0, 32, 8'h3C, 8'h3C); send(32, 0, 1); drain();
        sc0 = 8'd1; sc1 = 8'd200;
        fill(0, 16, 8'h3C, 8'h3C); fill(16, 32, 8'hBC, 8'h3C); send(32, 0, 1); drain();
        fill(0, 32, 8'h7B, 8'hFB); send(32, 0, 1); drain();
        fill(0, 32, 8'h3C, 8'h01); send(32, 50, 1); drain();

        hold_req = 5;
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            a_buf[k] = 8'($urandom);
            b_buf[k] = 8'($urandom);
        end
        send(32, 20, 1); drain();
        hold_req = 0;

        // Abort a block after 10 pairs with an asynchronous reset.
        fill(0, 32, 8'h01, 8'h01); send(10, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_ready", o_ready, 1'b0);
        check("midreset_valid", o_valid, 1'b0);
        check("midreset_acc", o_acc, 0);
        check("midreset_busy", o_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32, 0, 1); drain();

        for (int blk = 0; blk < 4; blk++) begin
            sc0 = 8'($urandom);
            sc1 = (blk == 2) ? 8'hFF : 8'($urandom);
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                a_buf[k] = 8'($urandom);
                b_buf[k] = 8'($urandom);
            end
            send(32, 30, 1);
        end
        drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mx_dot_seq.md
Name: mx_dot_seq

Overview:
- Sequencer that time-shares one combinational mul_fp instance across the element pairs of an MX block and accumulates the exact fixed-point products into one block dot product.
- Sits between the MX element stream (two operand vectors, one pair per beat) and the block-result consumer.
- Accepts one element pair per cycle via valid/ready, counts BLOCK_SIZE pairs, then presents the exact signed sum via valid/ready.

Parameters:
- exp_width, 5, element exponent width, passed to mul_fp.
- man_width, 2, element mantissa width, passed to mul_fp.
- BLOCK_SIZE, 32, element pairs per block (>=2).
- Derived, not overridable:
  - bit_width = 1+exp_width+man_width.
  - prd_width = 2*((1<<exp_width)+man_width).
  - acc_width = prd_width+$clog2(BLOCK_SIZE)+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  element pair valid.
- o_ready  out  1  sequencer can accept pair.
- i_op0  in  bit_width  element of vector A (sign, exp, man).
- i_op1  in  bit_width  element of vector B.
- o_valid  out  1  block result valid.
- i_ready  in  1  consumer accepts result.
- o_acc  out  acc_width  signed dot product, LSB = (min subnormal)^2, same scaling as mul_fp o_prd.
- o_busy  out  1  high from the first accepted pair until the result handshake.

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). Reset values: o_ready=0, o_valid=0, o_acc=0, o_busy=0, count=0, product register=0, state=IDLE.
- States and transitions:
  - IDLE: o_ready=1. On the first pair accepted -> ACCUM.
  - ACCUM: o_ready=1 while count<BLOCK_SIZE. On acceptance of pair number BLOCK_SIZE -> DRAIN.
  - DRAIN: o_ready=0. One cycle, lets the last product retire -> DONE.
  - DONE: o_valid=1, o_ready=0. On i_valid... on o_valid&&i_ready: clear acc and count, -> IDLE.
- Pipeline:
  - Stage 1 registers the mul_fp product of the accepted pair together with a valid bit.
  - Stage 2 adds the sign-extended product into acc.
  - The last pair accepted at cycle N gives o_valid=1 at cycle N+2, with o_acc final.
- Handshake rules:
  - A pair is consumed only on i_valid&&o_ready.
  - i_valid gaps are allowed and leave count and acc unchanged.
  - i_op0/i_op1 are ignored when not consumed.
- o_ready is registered and does not depend combinationally on i_valid. o_ready goes low in IDLE the cycle after reset deassertion... no: o_ready rises the first cycle after rst_n deasserts.
- Result hold:
  - o_acc and o_valid hold stable while i_ready=0; no pairs are accepted during the hold.
  - The result handshake and the next block's first pair cannot coincide; o_ready returns one cycle after the handshake.
- Arithmetic:
  - Exact, no rounding. acc_width guarantees no overflow for BLOCK_SIZE maximum-magnitude products of either sign.
  - All codes, including exp field all-ones, are treated as normal finite values, as mul_fp does.
  - +0 and -0 products are both 0.
- Count:
  - Width $clog2(BLOCK_SIZE+1).
  - Resets to 0 on the result handshake. It never wraps, because acceptance stops at BLOCK_SIZE.
- Reset mid-block: all state is cleared immediately and asynchronously. The partial sum is discarded and no o_valid is produced for that block.

Optional Feature:
- MX_DOT_SCALE_EN defined adds these ports:
  - i_scale0 and i_scale1, in, 8 bits, E8M0 shared scales, sampled with the first pair of a block and held.
  - o_exp, out, 10 bits signed, = i_scale0+i_scale1-254, valid with o_valid.
  - o_nan, out, 1 bit, set if either scale == 8'hFF.
  - Reset values: o_exp=0, o_nan=0.
- Not defined: the ports are absent and behaviour is otherwise identical.

Test Plan:
- BLOCK_SIZE=32, 32 pairs (0x01,0x01) back-to-back -> o_valid at cycle N+2, o_acc=32.
- 32 pairs (0x3C,0x3C) (1.0*1.0) -> o_acc=32*2^32=2^37.
- 16 pairs (0x3C,0x3C) then 16 pairs (0xBC,0x3C) -> o_acc=0. 32 pairs (0x7B,0xFB) -> o_acc=-49*2^63, no overflow.
- Random i_valid gaps (about 50%) with 32 pairs (0x3C,0x01) -> o_acc=32*2^16; count and o_busy correct throughout.
- i_ready held low 5 cycles in DONE -> o_valid and o_acc stable, o_ready=0. Handshake -> o_ready=1 next cycle, o_acc=0.
- rst_n pulsed after 10 pairs -> outputs at reset values at once. A following full block of (0x01,0x01) -> o_acc=32, not 42. With MX_DOT_SCALE_EN, scales 127,130 -> o_exp=3; scale 255 -> o_nan=1.
